// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator advanced by the pixel-rate beat strobe.
// Define VGA_TIMING_FRAME_CNT_EN to add the completed-frame counter port frame_cnt.
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        beat,
    input  logic        run,
    output logic        busy,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic        frame_start,
    output logic [15:0] frame_cnt
`else
    output logic        frame_start
`endif
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic       SYNC_ON  = (SYNC_POL != 0);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [9:0] hc;
    logic [9:0] vc;
    logic [9:0] hc_nxt;
    logic [9:0] vc_nxt;
    logic       ls_nxt;
    logic       fs_nxt;
    logic       wrap;
    logic       de_nxt;
    logic       hs_win;
    logic       vs_win;

    // run is only consulted at the frame wrap, so a frame is never cut short.
    always_comb begin
        state_nxt = state;
        hc_nxt    = hc;
        vc_nxt    = vc;
        ls_nxt    = 1'b0;
        fs_nxt    = 1'b0;
        wrap      = 1'b0;
        case (state)
            IDLE: begin
                if (beat && run) begin
                    state_nxt = RUN;
                    hc_nxt    = '0;
                    vc_nxt    = '0;
                    ls_nxt    = 1'b1;
                    fs_nxt    = 1'b1;
                end
            end
            RUN: begin
                if (beat) begin
                    if (hc == H_LAST) begin
                        hc_nxt = '0;
                        if (vc == V_LAST) begin
                            vc_nxt = '0;
                            wrap   = 1'b1;
                            if (run) begin
                                ls_nxt = 1'b1;
                                fs_nxt = 1'b1;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            vc_nxt = vc + 10'd1;
                            ls_nxt = 1'b1;
                        end
                    end else begin
                        hc_nxt = hc + 10'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        de_nxt = (hc_nxt < H_ACT) && (vc_nxt < V_ACT);
        hs_win = (hc_nxt >= HS_FIRST) && (hc_nxt <= HS_LAST);
        vs_win = (vc_nxt >= VS_FIRST) && (vc_nxt <= VS_LAST);
    end

    // Outputs decode the counter value being loaded, so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hc          <= '0;
            vc          <= '0;
            busy        <= 1'b0;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            hc          <= hc_nxt;
            vc          <= vc_nxt;
            busy        <= (state_nxt == RUN);
            line_start  <= ls_nxt;
            frame_start <= fs_nxt;
            if (state_nxt == RUN) begin
                hsync <= hs_win ? SYNC_ON : ~SYNC_ON;
                vsync <= vs_win ? SYNC_ON : ~SYNC_ON;
                de    <= de_nxt;
                x     <= de_nxt ? hc_nxt : 10'd0;
                y     <= de_nxt ? vc_nxt : 10'd0;
            end else begin
                hsync <= ~SYNC_ON;
                vsync <= ~SYNC_ON;
                de    <= 1'b0;
                x     <= '0;
                y     <= '0;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: a full-size instance for line timing and
// two reduced-raster instances (active-low and active-high sync) for frame-level behaviour.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic beat;
    logic run;

    always #5 clk = ~clk;

    logic       d_busy, d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_busy, s_hs, s_vs, s_de, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic       p_busy, p_hs, p_vs, p_de, p_ls, p_fs;
    logic [9:0] p_x, p_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] d_fc, s_fc, p_fc;
`endif

    int checks = 0;
    int errors = 0;

    vga_timing_ctrl dut_d (
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(d_fc),
`endif
        .clk(clk), .reset(reset), .beat(beat), .run(run), .busy(d_busy),
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .x(d_x), .y(d_y),
        .line_start(d_ls), .frame_start(d_fs)
    );

    // Reduced raster: H_TOTAL = 15 (hsync at 10..12), V_TOTAL = 8 (vsync at 5..6).
    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(0)
    ) dut_s (
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(s_fc),
`endif
        .clk(clk), .reset(reset), .beat(beat), .run(run), .busy(s_busy),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
        .line_start(s_ls), .frame_start(s_fs)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1)
    ) dut_p (
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(p_fc),
`endif
        .clk(clk), .reset(reset), .beat(beat), .run(run), .busy(p_busy),
        .hsync(p_hs), .vsync(p_vs), .de(p_de), .x(p_x), .y(p_y),
        .line_start(p_ls), .frame_start(p_fs)
    );

    task automatic tick(input logic b);
        beat = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        beat  = 1'b0;
        run   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [25:0] got, exp;
        reset = 1'b1;
        beat  = 1'b0;
        run   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp = {1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        got = {d_busy, d_de, d_x, d_y, d_hs, d_vs, d_ls, d_fs};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_d: got %h exp %h", got, exp); end
        got = {s_busy, s_de, s_x, s_y, s_hs, s_vs, s_ls, s_fs};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_s: got %h exp %h", got, exp); end
        exp = {1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        got = {p_busy, p_de, p_x, p_y, p_hs, p_vs, p_ls, p_fs};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_p: got %h exp %h", got, exp); end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if ({d_fc, s_fc, p_fc} !== 48'd0) begin
            errors++; $display("FAIL reset_fc: got %h %h %h exp 0", d_fc, s_fc, p_fc);
        end
`endif
        reset = 1'b0;
        tick(1'b1);
        checks++;
        if ({d_busy, d_fs, d_de} !== 3'b000) begin
            errors++; $display("FAIL beat_without_run: got %b exp 000", {d_busy, d_fs, d_de});
        end
    endtask

    task automatic test_line();
        logic [25:0] got, exp;
        logic [12:0] g2, e2;
        logic        e_de;
        logic [9:0]  e_x, e_y;
        int          hc, vc, hs_cnt, hs_first;
        do_reset();
        run = 1'b1;
        hs_cnt = 0;
        hs_first = -1;
        for (int k = 0; k <= 1600; k++) begin
            hc = k % 800;
            vc = k / 800;
            e_de = (hc < 640) && (vc < 480);
            e_x = e_de ? 10'(hc) : 10'd0;
            e_y = e_de ? 10'(vc) : 10'd0;
            tick(1'b1);
            exp = {1'b1, e_de, e_x, e_y, !(hc >= 656 && hc <= 751), 1'b1, hc == 0, k == 0};
            got = {d_busy, d_de, d_x, d_y, d_hs, d_vs, d_ls, d_fs};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL line_beat k=%0d: got %h exp %h", k, got, exp); end
            if (k < 800 && d_hs == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = hc;
            end
            tick(1'b0);
            e2 = {1'b0, 1'b0, e_de, e_x};
            g2 = {d_ls, d_fs, d_de, d_x};
            checks++;
            if (g2 !== e2) begin errors++; $display("FAIL line_hold k=%0d: got %h exp %h", k, g2, e2); end
            tick(1'b0);
            tick(1'b0);
        end
        checks++;
        if (hs_cnt !== 96 || hs_first !== 656) begin
            errors++; $display("FAIL hsync_window: got len %0d start %0d exp len 96 start 656", hs_cnt, hs_first);
        end
    endtask

    task automatic test_frame();
        logic [25:0] got, exp;
        logic        e_de;
        logic [9:0]  e_x, e_y;
        int          hc, vc, vs_cnt, fs_cnt;
        do_reset();
        run = 1'b1;
        vs_cnt = 0;
        fs_cnt = 0;
        for (int k = 0; k <= 360; k++) begin
            hc = k % 15;
            vc = (k / 15) % 8;
            e_de = (hc < 8) && (vc < 4);
            e_x = e_de ? 10'(hc) : 10'd0;
            e_y = e_de ? 10'(vc) : 10'd0;
            tick(1'b1);
            exp = {1'b1, e_de, e_x, e_y, !(hc >= 10 && hc <= 12), !(vc >= 5 && vc <= 6),
                   hc == 0, (k % 120) == 0};
            got = {s_busy, s_de, s_x, s_y, s_hs, s_vs, s_ls, s_fs};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL frame_beat k=%0d: got %h exp %h", k, got, exp); end
`ifdef VGA_TIMING_FRAME_CNT_EN
            checks++;
            if (s_fc !== 16'(k / 120)) begin
                errors++; $display("FAIL frame_cnt k=%0d: got %0d exp %0d", k, s_fc, k / 120);
            end
`endif
            if (k < 120 && s_vs == 1'b0) vs_cnt++;
            if (s_fs) fs_cnt++;
            tick(1'b0);
            checks++;
            if ({s_ls, s_fs} !== 2'b00) begin
                errors++; $display("FAIL frame_pulse_clear k=%0d: got %b exp 00", k, {s_ls, s_fs});
            end
        end
        checks++;
        if (vs_cnt !== 30 || fs_cnt !== 4) begin
            errors++; $display("FAIL vsync_len: got vs %0d fs %0d exp vs 30 fs 4", vs_cnt, fs_cnt);
        end
    endtask

    task automatic test_sync_pol();
        logic [12:0] got, exp;
        logic        e_de;
        int          hc, vc, hs_cnt;
        do_reset();
        run = 1'b1;
        hs_cnt = 0;
        for (int k = 0; k < 105; k++) begin
            hc = k % 15;
            vc = k / 15;
            e_de = (hc < 8) && (vc < 4);
            tick(1'b1);
            exp = {(hc >= 10 && hc <= 12), (vc >= 5 && vc <= 6), e_de, e_de ? 10'(hc) : 10'd0};
            got = {p_hs, p_vs, p_de, p_x};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL sync_pol k=%0d: got %h exp %h", k, got, exp); end
            if (k < 15 && p_hs) hs_cnt++;
        end
        checks++;
        if (hs_cnt !== 3) begin errors++; $display("FAIL sync_pol_len: got %0d exp 3", hs_cnt); end
    endtask

    task automatic test_stop();
        logic [25:0] got, exp;
        logic        e_de;
        logic [9:0]  e_x, e_y;
        int          hc, vc;
        do_reset();
        run = 1'b1;
        for (int k = 0; k <= 120; k++) begin
            hc = k % 15;
            vc = (k / 15) % 8;
            if (k == 31) run = 1'b0;
            e_de = (k < 120) && (hc < 8) && (vc < 4);
            e_x = e_de ? 10'(hc) : 10'd0;
            e_y = e_de ? 10'(vc) : 10'd0;
            tick(1'b1);
            if (k < 120)
                exp = {1'b1, e_de, e_x, e_y, !(hc >= 10 && hc <= 12), !(vc >= 5 && vc <= 6),
                       hc == 0, k == 0};
            else
                exp = {1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
            got = {s_busy, s_de, s_x, s_y, s_hs, s_vs, s_ls, s_fs};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL stop k=%0d: got %h exp %h", k, got, exp); end
        end
        for (int k = 0; k < 5; k++) tick(1'b1);
        checks++;
        if ({s_busy, s_fs} !== 2'b00) begin errors++; $display("FAIL stop_idle: got %b exp 00", {s_busy, s_fs}); end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (s_fc !== 16'd1) begin errors++; $display("FAIL stop_fc: got %0d exp 1", s_fc); end
`endif
        run = 1'b1;
        tick(1'b0);
        checks++;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL restart_wait: got %b exp 0", s_busy); end
        tick(1'b1);
        checks++;
        if ({s_busy, s_fs, s_ls, s_de, s_x, s_y} !== {4'b1111, 20'd0}) begin
            errors++; $display("FAIL restart: got %h exp %h", {s_busy, s_fs, s_ls, s_de, s_x, s_y}, {4'b1111, 20'd0});
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (s_fc !== 16'd1) begin errors++; $display("FAIL restart_fc: got %0d exp 1", s_fc); end
`endif
    endtask

    task automatic test_wrap_fall();
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 240; k++) begin
            tick(1'b1);
            if (k == 120) begin
                checks++;
                if ({s_busy, s_fs} !== 2'b11) begin
                    errors++; $display("FAIL wrap_continue: got %b exp 11", {s_busy, s_fs});
                end
            end
        end
        run = 1'b0;
        tick(1'b1);
        checks++;
        if ({s_busy, s_fs, s_ls, s_de, s_hs, s_vs} !== 6'b000011) begin
            errors++; $display("FAIL wrap_fall: got %b exp 000011", {s_busy, s_fs, s_ls, s_de, s_hs, s_vs});
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (s_fc !== 16'd2) begin errors++; $display("FAIL wrap_fall_fc: got %0d exp 2", s_fc); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        run = 1'b1;
        for (int k = 0; k <= 85; k++) tick(1'b1);
        checks++;
        if ({s_busy, s_hs, s_vs, d_de, d_x} !== {3'b100, 1'b1, 10'd85}) begin
            errors++; $display("FAIL pre_reset: got %h exp %h", {s_busy, s_hs, s_vs, d_de, d_x}, {3'b100, 1'b1, 10'd85});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({s_busy, s_hs, s_vs, d_busy, d_de, d_x, d_y, d_hs, d_vs} !== {3'b011, 2'b00, 20'd0, 2'b11}) begin
            errors++; $display("FAIL async_reset: got %h exp %h",
                {s_busy, s_hs, s_vs, d_busy, d_de, d_x, d_y, d_hs, d_vs}, {3'b011, 2'b00, 20'd0, 2'b11});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        run = 1'b1;
        tick(1'b1);
        checks++;
        if ({s_busy, s_fs, s_ls, s_de, s_x, s_y} !== {4'b1111, 20'd0}) begin
            errors++; $display("FAIL reset_restart: got %h exp %h", {s_busy, s_fs, s_ls, s_de, s_x, s_y}, {4'b1111, 20'd0});
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (s_fc !== 16'd0) begin errors++; $display("FAIL reset_restart_fc: got %0d exp 0", s_fc); end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        beat  = 1'b0;
        run   = 1'b0;
        test_reset();
        test_line();
        test_frame();
        test_sync_pol();
        test_stop();
        test_wrap_fall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequences VGA raster timing from the pixel-rate `beat` strobe produced by the clock divider: counts pixels and lines, drives hsync/vsync, data-enable and the active-area pixel coordinates, and starts/stops the raster cleanly on frame boundaries. It sits between the clock divider and the pixel source/DAC stage. All counters advance only on cycles where `beat` is high.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, active level of hsync/vsync (0 = active-low)

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `beat`  in  1  pixel-rate strobe, one `clk` wide
- `run`  in  1  level request to produce frames
- `busy`  out  1  high while in RUN
- `hsync`  out  1  horizontal sync, polarity per `SYNC_POL`
- `vsync`  out  1  vertical sync, polarity per `SYNC_POL`
- `de`  out  1  high in active area
- `x`  out  10  pixel column in active area, else 0
- `y`  out  10  pixel row in active area, else 0
- `line_start`  out  1  one-`clk` pulse when `hc` becomes 0
- `frame_start`  out  1  one-`clk` pulse when (`hc`,`vc`) becomes (0,0)
- `frame_cnt`  out  16  completed-frame count (only with `VGA_TIMING_FRAME_CNT_EN`)

## Operation
- H_TOTAL = sum of H parameters (800); V_TOTAL = sum of V parameters (525); both must be ≤ 1024 (10-bit counters `hc`, `vc`).
- States: IDLE, RUN.
- IDLE: `hc`=`vc`=0; hsync/vsync inactive (= ~SYNC_POL), `de`=0, `x`=`y`=0, `busy`=0, pulses 0. On edge with `run`=1 and `beat`=1 → RUN, counters load (0,0), `frame_start`=`line_start`=1.
- RUN, `beat`=1: `hc`++ ; at `hc`=H_TOTAL-1 → `hc`=0, `vc`++; at `vc`=V_TOTAL-1 also → `vc`=0. `beat`=0: everything holds, pulses clear.
- Stop: `run` sampled only at frame wrap (edge where counters would go to (0,0)). `run`=0 there → IDLE; `run`=1 → continue, `frame_start` pulses. Deasserting `run` mid-frame never truncates a frame.
- Decodes on new counter value: `de` = `hc`<H_ACTIVE && `vc`<V_ACTIVE; hsync active for `hc` in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1]; vsync active for `vc` in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1]; `x`=`hc`, `y`=`vc` when `de`, else 0.
- `beat` asserted on consecutive `clk` cycles is legal; each cycle is one pixel.

## Timing
- All outputs registered; reset values equal IDLE values (`frame_cnt`=0).
- `reset` asserted at any point (incl. mid-frame) forces IDLE outputs immediately, asynchronously; first frame after release starts at (0,0).
- Latency: outputs reflect the counter position loaded at the same `clk` edge that sampled `beat`=1 (zero extra pipeline); all outputs mutually aligned.
- `line_start`/`frame_start` high exactly one `clk`, on the edge the position is entered, regardless of `beat` width.
- Simultaneous frame wrap and `run` fall: stop wins (→ IDLE, no `frame_start`).

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: port `frame_cnt` present; increments by 1 on every frame wrap in RUN (including the wrap that stops), wraps 0xFFFF→0, holds in IDLE, cleared only by `reset`.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset then `run`=1, `beat` every 4 `clk`: first `beat` → `frame_start`=1, `de`=1, `x`=`y`=0; `x` reaches 639 then `de`=0 at `hc`=640.
- Full line: hsync active (0) for exactly 96 beats starting at `hc`=656; `line_start` every 800 beats.
- Full frame: vsync active for lines 490–491 (1600 beats); `frame_start` every 420000 beats; `frame_cnt` 0→1→2.
- Drop `run` at `vc`=100: raster continues to `vc`=524,`hc`=799; next beat → IDLE, `busy`=0, no `frame_start`.
- Assert `reset` at `hc`=300,`vc`=200: same cycle hsync/vsync=1, `de`=0, `x`=`y`=0; restart begins at (0,0).
- `SYNC_POL`=1, `beat` held high continuously: hsync=1 only in sync window, one pixel per `clk`.
